// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and elaboration helpers for the sync_fifo block.
//   fifo_flags_t - packed status flags derived from the read/write pointers
//   is_pow2      - true when n is a power of two and at least 2
package sync_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage array for sync_fifo.
// It has one synchronous write port and one asynchronous read port, so it maps
// onto distributed RAM.
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address (AW bits)
//   i_wdata - write data (P_WIDTH bits)
//   i_raddr - read address (AW bits)
//   o_rdata - combinational read data
module fifo_ram #(
  parameter int unsigned AW      = 4,
  parameter int unsigned P_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [P_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [P_WIDTH-1:0] o_rdata
);

  logic [P_WIDTH-1:0] r_mem [2**AW];

  // The contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on the write side and on the read side.
//   sys_clk  - clock; all state changes on the rising edge
//   sys_rst  - synchronous reset, active-high
//   wr_data  - word to enqueue
//   wr_vld   - the producer presents a word
//   wr_rdy   - the FIFO accepts a word this cycle (forced low during reset)
//   rd_data  - head word, read combinationally from the array
//   rd_vld   - the head word is valid
//   rd_rdy   - the consumer takes the head word this cycle
//   level    - number of stored words, from 0 to P_DEPTH
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned P_DEPTH = 16,
  parameter int unsigned P_WIDTH = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [$clog2(P_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(P_DEPTH);

  if (!is_pow2(P_DEPTH)) begin : g_bad_depth
    $error("sync_fifo: P_DEPTH must be a power of two and >= 2");
  end

  // The MSB of each pointer is a wrap bit. It separates full from empty when
  // the address bits are equal.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fifo_flags_t  w_flags;
  logic         w_wr_en;
  logic         w_rd_en;

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  always_comb begin
    w_flags       = '0;
    w_flags.empty = (r_wr_ptr == r_rd_ptr);
    w_flags.full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
  end

  assign wr_rdy  = !w_flags.full && !sys_rst;
  assign rd_vld  = !w_flags.empty;
  assign w_wr_en = wr_vld && wr_rdy;
  assign w_rd_en = rd_vld && rd_rdy;
  assign level   = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
    end
  end

  fifo_ram #(
    .AW      (AW),
    .P_WIDTH (P_WIDTH)
  ) u_ram (
    .i_clk   (sys_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (rd_data)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [WIDTH-1:0] wr_data;
  logic             wr_vld;
  logic             wr_rdy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_vld;
  logic             rd_rdy;
  logic [4:0]       level;

  int unsigned n_checks   = 0;
  int unsigned n_failures = 0;

  // Reference model: an ordered queue of the stored words.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] popped[$];
  int               max_level = 0;
  bit               last_wa, last_ra;

  always #5 sys_clk = ~sys_clk;

  sync_fifo #(
    .P_DEPTH (DEPTH),
    .P_WIDTH (WIDTH)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_data (wr_data),
    .wr_vld  (wr_vld),
    .wr_rdy  (wr_rdy),
    .rd_data (rd_data),
    .rd_vld  (rd_vld),
    .rd_rdy  (rd_rdy),
    .level   (level)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // The caller sets the inputs just after an edge. This task checks the
  // settled outputs against the model, clocks one edge and updates the model.
  task automatic step();
    bit wa, ra;
    #2;
    chk("wr_rdy", 32'(wr_rdy), 32'(!sys_rst && q.size() < DEPTH));
    chk("rd_vld", 32'(rd_vld), 32'(q.size() != 0));
    chk("level",  32'(level),  32'(q.size()));
    if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    wa = wr_vld && !sys_rst && (q.size() < DEPTH);
    ra = rd_rdy && (q.size() != 0);
    @(posedge sys_clk);
    #1;
    if (sys_rst) begin
      q.delete();
    end else begin
      if (ra) popped.push_back(q.pop_front());
      if (wa) q.push_back(wr_data);
    end
    if (int'(level) > max_level) max_level = int'(level);
    last_wa = wa;
    last_ra = ra;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    wr_data = d; wr_vld = 1'b1; rd_rdy = 1'b0;
    step();
    wr_vld = 1'b0;
  endtask

  task automatic drain();
    wr_vld = 1'b0; rd_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    rd_rdy = 1'b0;
  endtask

  logic [WIDTH-1:0] in_words [100];

  initial begin
    int sent, cycles;
    sys_rst = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0; wr_data = '0;
    @(posedge sys_clk);
    #1;

    // 1: reset held for three cycles with a write offered
    wr_vld = 1'b1; wr_data = 9'h055;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t1_rdy_in_rst", 32'(wr_rdy), 32'(0));
      step();
    end
    sys_rst = 1'b0; wr_vld = 1'b0;
    #1;
    chk("t1_rd_vld", 32'(rd_vld), 32'(0));
    chk("t1_level",  32'(level),  32'(0));
    chk("t1_wr_rdy", 32'(wr_rdy), 32'(1));
    step();

    // 2: a single word
    push(9'h1A5);
    chk("t2_vld",   32'(rd_vld),  32'(1));
    chk("t2_data",  32'(rd_data), 32'h1A5);
    chk("t2_level", 32'(level),   32'(1));
    rd_rdy = 1'b1; step(); rd_rdy = 1'b0;
    chk("t2_vld_after", 32'(rd_vld), 32'(0));
    chk("t2_lvl_after", 32'(level),  32'(0));
    step();

    // 3: fill to full, offer one extra word, then drain
    for (int i = 0; i < DEPTH; i++) push(9'(i));
    chk("t3_level_full", 32'(level),  32'(16));
    chk("t3_wr_rdy",     32'(wr_rdy), 32'(0));
    push(9'h0FF);
    chk("t3_extra_lost", 32'(level), 32'(16));
    popped.delete();
    drain();
    chk("t3_pop_count", 32'(popped.size()), 32'(16));
    for (int i = 0; i < popped.size(); i++) chk("t3_order", 32'(popped[i]), 32'(i));

    // 4: write and read together while full
    for (int i = 0; i < DEPTH; i++) push(9'(i + 32));
    wr_data = 9'h1C3; wr_vld = 1'b1; rd_rdy = 1'b1;
    step();
    chk("t4_only_read", 32'(level), 32'(15));
    rd_rdy = 1'b0;
    step();
    chk("t4_write_lands", 32'(level), 32'(16));
    wr_vld = 1'b0;
    drain();

    // 5: 100 words under random handshakes
    for (int i = 0; i < 100; i++) in_words[i] = 9'($urandom);
    popped.delete();
    max_level = 0;
    sent = 0; cycles = 0;
    while ((popped.size() < 100) && (cycles < 3000)) begin
      wr_vld  = (sent < 100) && ($urandom_range(0, 3) != 0);
      wr_data = (sent < 100) ? in_words[sent] : '0;
      rd_rdy  = ($urandom_range(0, 2) != 0);
      step();
      if (last_wa) sent++;
      cycles++;
    end
    wr_vld = 1'b0; rd_rdy = 1'b0;
    chk("t5_all_read", 32'(popped.size()), 32'(100));
    for (int i = 0; i < popped.size() && i < 100; i++)
      chk("t5_order", 32'(popped[i]), 32'(in_words[i]));
    chk("t5_level_bound", 32'(max_level <= 16), 32'(1));

    // 6: reset while seven words are stored
    for (int i = 0; i < 7; i++) push(9'(i + 100));
    chk("t6_level7", 32'(level), 32'(7));
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("t6_level0", 32'(level),  32'(0));
    chk("t6_vld0",   32'(rd_vld), 32'(0));
    push(9'h033);
    chk("t6_first_vld",  32'(rd_vld),  32'(1));
    chk("t6_first_data", 32'(rd_data), 32'h033);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_sync_fifo
